// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores with a fixed access latency, branch/jump redirect,
// and the registered bundle handed to write-back.
module mem_stage #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic [31:0] MEM_PC,
    input  logic [25:0] MEM_Jump_ins_add,
    input  logic        MEM_Zero,
    input  logic [31:0] MEM_ALU,
    input  logic [31:0] MEM_WriteData,
    input  logic [31:0] MEM_Extimm,
    input  logic [4:0]  MEM_Reg_Write,
    output logic        mem_stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        WB_MemtoReg,
    output logic        WB_RegWrite,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_ALU,
    output logic [31:0] WB_Result,
    output logic [4:0]  WB_Reg_Write,
    output logic        WB_Misalign
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       mem_q [DEPTH];

    logic              wb_m2r_q, wb_m2r_d;
    logic              wb_rw_q, wb_rw_d;
    logic [31:0]       wb_rdata_q, wb_rdata_d;
    logic [31:0]       wb_alu_q, wb_alu_d;
    logic [31:0]       wb_res_q, wb_res_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_mis_q, wb_mis_d;

    logic              access, aligned, misalign;
    logic              stall, complete, do_write, taken;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign access      = MEM_MemRead | MEM_MemWrite;
    assign aligned     = (MEM_ALU[1:0] == 2'b00);
    assign misalign    = access & ~aligned;
    assign idx         = MEM_ALU[ADDR_W+1:2];
    assign rdata       = mem_q[idx];
    assign unused_bits = ^{MEM_ALU[31:ADDR_W+2], MEM_Extimm[31:30]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && aligned && (LAT > 0)) begin
                    stall   = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_stall = stall & ~rst;
    assign taken     = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign redirect  = taken & ~mem_stall & ~rst;

    // Jump has priority over branch when both are flagged.
    assign redirect_pc = MEM_Jump ? {MEM_PC[31:28], MEM_Jump_ins_add, 2'b00}
                                  : MEM_PC + {MEM_Extimm[29:0], 2'b00};

    assign do_write = complete & MEM_MemWrite & aligned & ~rst;

    // Anything other than a completion cycle pushes a bubble toward write-back.
    always_comb begin
        wb_m2r_d   = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rdata_d = 32'd0;
        wb_alu_d   = 32'd0;
        wb_res_d   = 32'd0;
        wb_rd_d    = 5'd0;
        wb_mis_d   = 1'b0;
        if (complete) begin
            wb_m2r_d   = MEM_MemtoReg;
            wb_rw_d    = MEM_RegWrite & ~misalign;
            wb_rdata_d = rdata;
            wb_alu_d   = MEM_ALU;
            wb_res_d   = MEM_MemtoReg ? rdata : MEM_ALU;
            wb_rd_d    = MEM_Reg_Write;
            wb_mis_d   = misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[idx] <= MEM_WriteData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rdata_q <= 32'd0;
            wb_alu_q   <= 32'd0;
            wb_res_q   <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_res_q   <= wb_res_d;
            wb_rd_q    <= wb_rd_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    assign WB_MemtoReg  = wb_m2r_q;
    assign WB_RegWrite  = wb_rw_q;
    assign WB_ReadData  = wb_rdata_q;
    assign WB_ALU       = wb_alu_q;
    assign WB_Result    = wb_res_q;
    assign WB_Reg_Write = wb_rd_q;
    assign WB_Misalign  = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table on a LAT=0 instance, plus
// multi-cycle sequences on LAT=2 and LAT=3 instances sharing the same input bundle.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemtoReg, MEM_RegWrite, MEM_Branch, MEM_Jump, MEM_MemWrite, MEM_MemRead;
    logic [31:0] MEM_PC;
    logic [25:0] MEM_Jump_ins_add;
    logic        MEM_Zero;
    logic [31:0] MEM_ALU, MEM_WriteData, MEM_Extimm;
    logic [4:0]  MEM_Reg_Write;

    logic        stall_0, redir_0, m2r_0, rw_0, mis_0;
    logic [31:0] rpc_0, rdata_0, alu_0, res_0;
    logic [4:0]  rd_0;
    logic        stall_2, redir_2, m2r_2, rw_2, mis_2;
    logic [31:0] rpc_2, rdata_2, alu_2, res_2;
    logic [4:0]  rd_2;
    logic        stall_3, redir_3, m2r_3, rw_3, mis_3;
    logic [31:0] rpc_3, rdata_3, alu_3, res_3;
    logic [4:0]  rd_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(10), .LAT(0)) u0 (
        .clk(clk), .rst(rst),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite), .MEM_Branch(MEM_Branch),
        .MEM_Jump(MEM_Jump), .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_PC(MEM_PC), .MEM_Jump_ins_add(MEM_Jump_ins_add), .MEM_Zero(MEM_Zero),
        .MEM_ALU(MEM_ALU), .MEM_WriteData(MEM_WriteData), .MEM_Extimm(MEM_Extimm),
        .MEM_Reg_Write(MEM_Reg_Write),
        .mem_stall(stall_0), .redirect(redir_0), .redirect_pc(rpc_0),
        .WB_MemtoReg(m2r_0), .WB_RegWrite(rw_0), .WB_ReadData(rdata_0), .WB_ALU(alu_0),
        .WB_Result(res_0), .WB_Reg_Write(rd_0), .WB_Misalign(mis_0)
    );

    mem_stage #(.ADDR_W(10), .LAT(2)) u2 (
        .clk(clk), .rst(rst),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite), .MEM_Branch(MEM_Branch),
        .MEM_Jump(MEM_Jump), .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_PC(MEM_PC), .MEM_Jump_ins_add(MEM_Jump_ins_add), .MEM_Zero(MEM_Zero),
        .MEM_ALU(MEM_ALU), .MEM_WriteData(MEM_WriteData), .MEM_Extimm(MEM_Extimm),
        .MEM_Reg_Write(MEM_Reg_Write),
        .mem_stall(stall_2), .redirect(redir_2), .redirect_pc(rpc_2),
        .WB_MemtoReg(m2r_2), .WB_RegWrite(rw_2), .WB_ReadData(rdata_2), .WB_ALU(alu_2),
        .WB_Result(res_2), .WB_Reg_Write(rd_2), .WB_Misalign(mis_2)
    );

    mem_stage #(.ADDR_W(10), .LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite), .MEM_Branch(MEM_Branch),
        .MEM_Jump(MEM_Jump), .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_PC(MEM_PC), .MEM_Jump_ins_add(MEM_Jump_ins_add), .MEM_Zero(MEM_Zero),
        .MEM_ALU(MEM_ALU), .MEM_WriteData(MEM_WriteData), .MEM_Extimm(MEM_Extimm),
        .MEM_Reg_Write(MEM_Reg_Write),
        .mem_stall(stall_3), .redirect(redir_3), .redirect_pc(rpc_3),
        .WB_MemtoReg(m2r_3), .WB_RegWrite(rw_3), .WB_ReadData(rdata_3), .WB_ALU(alu_3),
        .WB_Result(res_3), .WB_Reg_Write(rd_3), .WB_Misalign(mis_3)
    );

    // ctl = {MemtoReg, RegWrite, Branch, Jump, MemWrite, MemRead, Zero}
    // eflg = {redirect, WB_RegWrite, WB_MemtoReg, WB_Misalign}
    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] ext;
        logic [25:0] jidx;
        logic [4:0]  rd;
        logic [3:0]  eflg;
        logic [31:0] e_rpc;
        logic [31:0] e_rdata;
        logic [31:0] e_alu;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] ext, input logic [25:0] jidx,
                         input logic [4:0] rd);
        {MEM_MemtoReg, MEM_RegWrite, MEM_Branch, MEM_Jump, MEM_MemWrite, MEM_MemRead, MEM_Zero} = ctl;
        MEM_PC           = pc;
        MEM_ALU          = alu;
        MEM_WriteData    = wd;
        MEM_Extimm       = ext;
        MEM_Jump_ins_add = jidx;
        MEM_Reg_Write    = rd;
    endtask

    // Runs the held instruction until its completion edge; returns cycles taken.
    task automatic run_access(input int sel, output int cyc);
        logic st;
        cyc = 0;
        st  = 1'b1;
        while (st && cyc < 40) begin
            #1;
            st = (sel == 3) ? stall_3 : stall_2;
            @(posedge clk);
            #1;
            cyc++;
            if (st) begin
                chk("bubble_regwrite", 32'((sel == 3) ? rw_3 : rw_2), 32'd0);
                chk("bubble_alu", (sel == 3) ? alu_3 : alu_2, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        tbl[0]  = '{7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0, 5'd0,
                    4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl[1]  = '{7'b0000100, 32'h0, 32'h10, 32'hDEADBEEF, 32'h0, 26'h0, 5'd0,
                    4'b0000, 32'h0, 32'h0, 32'h10, 32'h10, 5'd0};
        tbl[2]  = '{7'b1100010, 32'h0, 32'h10, 32'h0, 32'h0, 26'h0, 5'd5,
                    4'b0110, 32'h0, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 5'd5};
        tbl[3]  = '{7'b1100010, 32'h0, 32'h13, 32'h0, 32'h0, 26'h0, 5'd6,
                    4'b0011, 32'h0, 32'hDEADBEEF, 32'h13, 32'hDEADBEEF, 5'd6};
        tbl[4]  = '{7'b0000100, 32'h0, 32'h12, 32'h12345678, 32'h0, 26'h0, 5'd0,
                    4'b0001, 32'h0, 32'hDEADBEEF, 32'h12, 32'h12, 5'd0};
        tbl[5]  = '{7'b1100010, 32'h0, 32'h10, 32'h0, 32'h0, 26'h0, 5'd5,
                    4'b0110, 32'h0, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 5'd5};
        tbl[6]  = '{7'b0010001, 32'h100, 32'h0, 32'h0, 32'hFFFFFFFC, 26'h0, 5'd0,
                    4'b1000, 32'hF0, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl[7]  = '{7'b0010000, 32'h100, 32'h0, 32'h0, 32'hFFFFFFFC, 26'h0, 5'd0,
                    4'b0000, 32'hF0, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl[8]  = '{7'b0001000, 32'h40000004, 32'h0, 32'h0, 32'h0, 26'h10, 5'd0,
                    4'b1000, 32'h40000040, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl[9]  = '{7'b0011001, 32'h40000004, 32'h0, 32'h0, 32'h4, 26'h10, 5'd0,
                    4'b1000, 32'h40000040, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl[10] = '{7'b0000100, 32'h0, 32'h1000, 32'h1, 32'h0, 26'h0, 5'd0,
                    4'b0000, 32'h0, 32'h0, 32'h1000, 32'h1000, 5'd0};
        tbl[11] = '{7'b1100010, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0, 5'd3,
                    4'b0110, 32'h0, 32'h1, 32'h0, 32'h1, 5'd3};
        tbl[12] = '{7'b0100000, 32'h0, 32'hABCD, 32'h0, 32'h0, 26'h0, 5'd7,
                    4'b0100, 32'h0, 32'h0, 32'hABCD, 32'hABCD, 5'd7};

        rst = 1'b1;
        drive(7'b0, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle behaviour, LAT=0 instance
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ctl, tbl[i].pc, tbl[i].alu, tbl[i].wd, tbl[i].ext, tbl[i].jidx, tbl[i].rd);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall_0), 32'd0);
            chk($sformatf("v%0d_redirect", i), 32'(redir_0), 32'(tbl[i].eflg[3]));
            chk($sformatf("v%0d_redirect_pc", i), rpc_0, tbl[i].e_rpc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb_regwrite", i), 32'(rw_0), 32'(tbl[i].eflg[2]));
            chk($sformatf("v%0d_wb_memtoreg", i), 32'(m2r_0), 32'(tbl[i].eflg[1]));
            chk($sformatf("v%0d_wb_misalign", i), 32'(mis_0), 32'(tbl[i].eflg[0]));
            chk($sformatf("v%0d_wb_readdata", i), rdata_0, tbl[i].e_rdata);
            chk($sformatf("v%0d_wb_alu", i), alu_0, tbl[i].e_alu);
            chk($sformatf("v%0d_wb_result", i), res_0, tbl[i].e_res);
            chk($sformatf("v%0d_wb_rd", i), 32'(rd_0), 32'(tbl[i].e_rd));
        end

        // Asynchronous reset mid-cycle
        drive(7'b1101010, 32'h0, 32'h10, 32'h0, 32'h0, 26'h3, 5'd9);
        repeat (3) @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        chk("rst_wb_regwrite", 32'(rw_2), 32'd0);
        chk("rst_wb_memtoreg", 32'(m2r_2), 32'd0);
        chk("rst_wb_misalign", 32'(mis_2), 32'd0);
        chk("rst_wb_readdata", rdata_2, 32'd0);
        chk("rst_wb_alu", alu_2, 32'd0);
        chk("rst_wb_result", res_2, 32'd0);
        chk("rst_wb_rd", 32'(rd_2), 32'd0);
        chk("rst_stall", 32'(stall_2), 32'd0);
        chk("rst_redirect", 32'(redir_2), 32'd0);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("nop_wb_regwrite", 32'(rw_2), 32'd0);

        // LAT=2 store then load
        drive(7'b0000100, 32'h0, 32'h10, 32'hDEADBEEF, 32'h0, 26'h0, 5'd0);
        run_access(2, c);
        chk("l2_store_cycles", 32'(c), 32'd3);
        chk("l2_store_wb_alu", alu_2, 32'h10);
        drive(7'b1100010, 32'h0, 32'h10, 32'h0, 32'h0, 26'h0, 5'd5);
        run_access(2, c);
        chk("l2_load_cycles", 32'(c), 32'd3);
        chk("l2_load_result", res_2, 32'hDEADBEEF);
        chk("l2_load_rd", 32'(rd_2), 32'd5);
        chk("l2_load_regwrite", 32'(rw_2), 32'd1);

        // LAT=2 misaligned accesses
        drive(7'b1100010, 32'h0, 32'h13, 32'h0, 32'h0, 26'h0, 5'd6);
        run_access(2, c);
        chk("l2_misld_cycles", 32'(c), 32'd1);
        chk("l2_misld_misalign", 32'(mis_2), 32'd1);
        chk("l2_misld_regwrite", 32'(rw_2), 32'd0);
        drive(7'b0000100, 32'h0, 32'h12, 32'h12345678, 32'h0, 26'h0, 5'd0);
        run_access(2, c);
        chk("l2_misst_cycles", 32'(c), 32'd1);
        drive(7'b1100010, 32'h0, 32'h10, 32'h0, 32'h0, 26'h0, 5'd5);
        run_access(2, c);
        chk("l2_reload_result", res_2, 32'hDEADBEEF);

        // LAT=3 reset during the second stall cycle
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(7'b0000100, 32'h0, 32'h20, 32'h55, 32'h0, 26'h0, 5'd0);
        #1;
        chk("l3_stall_c1", 32'(stall_3), 32'd1);
        @(posedge clk);
        #1;
        chk("l3_stall_c2", 32'(stall_3), 32'd1);
        #4;
        rst = 1'b1;
        #1;
        chk("l3_rst_stall", 32'(stall_3), 32'd0);
        drive(7'b1100010, 32'h0, 32'h20, 32'h0, 32'h0, 26'h0, 5'd9);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_access(3, c);
        chk("l3_probe_cycles", 32'(c), 32'd4);
        chk("l3_word_unchanged", rdata_3, 32'h0);
        drive(7'b0000100, 32'h0, 32'h20, 32'h55, 32'h0, 26'h0, 5'd0);
        run_access(3, c);
        chk("l3_store_cycles", 32'(c), 32'd4);
        drive(7'b1100010, 32'h0, 32'h20, 32'h0, 32'h0, 26'h0, 5'd9);
        run_access(3, c);
        chk("l3_load_result", res_3, 32'h55);
        chk("l3_load_rd", 32'(rd_3), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
